// File: rtl/div_seq.sv
// Sequential restoring divider for RISC-V M-extension DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_SEQ_EARLY_OUT_EN to skip the iterations for divide-by-zero and signed overflow.
module div_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         div_load,
  input  logic         dact,
  input  logic         flush,
  input  logic [2:0]   funct3,
  input  logic         div_res_sel,
  input  logic [W-1:0] lhs,
  input  logic [W-1:0] rhs,
  input  logic [4:0]   in_rd,
  output logic [W-1:0] result,
  output logic         rslt_valid,
  output logic [4:0]   out_rd,
  output logic         busy
);

  // state   | meaning
  // IDLE    | no operation pending
  // LOADED  | operands latched, waiting for dact
  // CALC    | W shift-subtract iterations
  // FIX     | apply signs and special cases, register result
  // DONE    | result held, rslt_valid pulsed on entry
  typedef enum logic [2:0] {S_IDLE, S_LOADED, S_CALC, S_FIX, S_DONE} state_t;

  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  state_t         state_q;
  logic [W-1:0]   lhs_q, rhs_q, rem_q, quo_q, dvs_q, result_q;
  logic [2:0]     f3_q;
  logic           sel_q;
  logic [4:0]     rd_q, out_rd_q;
  logic           valid_q;
  logic [CW-1:0]  cnt_q;

  logic           is_signed, div_zero, sgn_ovf, q_neg, r_neg;
  logic [W-1:0]   lhs_abs, rhs_abs, rem_d, quo_d, q_fix, r_fix, result_d;
  logic [W:0]     part, diff;
  logic           unused_f3;

  assign unused_f3 = ^f3_q[2:1];

  always_comb begin
    is_signed = ~f3_q[0];
    lhs_abs   = (is_signed && lhs_q[W-1]) ? -lhs_q : lhs_q;
    rhs_abs   = (is_signed && rhs_q[W-1]) ? -rhs_q : rhs_q;
    div_zero  = (rhs_q == '0);
    sgn_ovf   = is_signed && (lhs_q == MIN_NEG) && (rhs_q == '1);
    q_neg     = is_signed && (lhs_q[W-1] ^ rhs_q[W-1]);
    r_neg     = is_signed && lhs_q[W-1];

    // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
    part = {rem_q, quo_q[W-1]};
    diff = part - {1'b0, dvs_q};
    if (!diff[W]) begin
      rem_d = diff[W-1:0];
      quo_d = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_d = part[W-1:0];
      quo_d = {quo_q[W-2:0], 1'b0};
    end

    q_fix = q_neg ? -quo_q : quo_q;
    r_fix = r_neg ? -rem_q : rem_q;
    // Special cases are forced here so the early-out path never depends on iteration results.
    if (div_zero)     result_d = sel_q ? lhs_q : '1;
    else if (sgn_ovf) result_d = sel_q ? '0 : MIN_NEG;
    else              result_d = sel_q ? r_fix : q_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lhs_q    <= '0;
      rhs_q    <= '0;
      f3_q     <= '0;
      sel_q    <= 1'b0;
      rd_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      out_rd_q <= '0;
      valid_q  <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state_q == S_FIX);
      if (div_load && (state_q == S_IDLE || state_q == S_LOADED || state_q == S_DONE)) begin
        lhs_q   <= lhs;
        rhs_q   <= rhs;
        f3_q    <= funct3;
        sel_q   <= div_res_sel;
        rd_q    <= in_rd;
        state_q <= S_LOADED;
      end else begin
        case (state_q)
          S_LOADED: if (dact) begin
            rem_q <= '0;
            quo_q <= lhs_abs;
            dvs_q <= rhs_abs;
`ifdef DIV_SEQ_EARLY_OUT_EN
            if (div_zero || sgn_ovf) begin
              cnt_q   <= '0;
              state_q <= S_FIX;
            end else begin
              cnt_q   <= CW'(W);
              state_q <= S_CALC;
            end
`else
            cnt_q   <= CW'(W);
            state_q <= S_CALC;
`endif
          end
          S_CALC: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= S_FIX;
          end
          S_FIX: begin
            result_q <= result_d;
            out_rd_q <= rd_q;
            state_q  <= S_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign result     = result_q;
  assign rslt_valid = valid_q;
  assign out_rd     = out_rd_q;
  assign busy       = (state_q == S_LOADED) || (state_q == S_CALC) || (state_q == S_FIX);

endmodule

// File: tb/tb_div_seq.sv
// Directed scoreboard bench for div_seq: arithmetic, special cases, latency, flush and reset abort.
module tb_div_seq;
  localparam int W = 32;
  localparam int LAT_FULL = W + 2;
`ifdef DIV_SEQ_EARLY_OUT_EN
  localparam int LAT_SPC = 2;
`else
  localparam int LAT_SPC = W + 2;
`endif
  localparam int TIMEOUT = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         div_load = 1'b0;
  logic         dact = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   funct3 = 3'b000;
  logic         div_res_sel = 1'b0;
  logic [W-1:0] lhs = '0;
  logic [W-1:0] rhs = '0;
  logic [4:0]   in_rd = '0;
  logic [W-1:0] result;
  logic         rslt_valid;
  logic [4:0]   out_rd;
  logic         busy;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   rd;
    int           lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  div_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .div_load(div_load), .dact(dact), .flush(flush),
    .funct3(funct3), .div_res_sel(div_res_sel), .lhs(lhs), .rhs(rhs), .in_rd(in_rd),
    .result(result), .rslt_valid(rslt_valid), .out_rd(out_rd), .busy(busy)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [2:0] f3, input logic sel,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd,
                       input logic [W-1:0] exp_res, input int lat, input int disturb,
                       input bit relatch);
    exp_t e;
    int n;
    if (relatch) begin
      div_load = 1'b1; funct3 = 3'b101; div_res_sel = ~sel;
      lhs = 32'h0000DEAD; rhs = 32'd3; in_rd = ~rd;
      step();
    end
    div_load = 1'b1; dact = relatch; funct3 = f3; div_res_sel = sel;
    lhs = a; rhs = b; in_rd = rd;
    step();
    div_load = 1'b0; dact = 1'b1;
    e.res = exp_res; e.rd = rd; e.lat = lat;
    sb.push_back(e);
    step();
    dact = 1'b0;
    n = 1;
    while (!rslt_valid && n < TIMEOUT) begin
      if (n == disturb) begin
        div_load = 1'b1; funct3 = 3'b101; div_res_sel = 1'b0;
        lhs = 32'd50; rhs = 32'd5; in_rd = 5'd9;
      end else begin
        div_load = 1'b0;
      end
      step();
      n++;
    end
    div_load = 1'b0;
    e = sb.pop_front();
    check({tag, "_latency"}, W'(n), W'(e.lat));
    check({tag, "_result"}, result, e.res);
    check({tag, "_out_rd"}, {27'd0, out_rd}, {27'd0, e.rd});
    step();
    check({tag, "_pulse_end"}, {31'd0, rslt_valid}, '0);
    check({tag, "_held"}, result, e.res);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd);
    div_load = 1'b1; funct3 = 3'b101; div_res_sel = 1'b0; lhs = a; rhs = b; in_rd = rd;
    step();
    div_load = 1'b0; dact = 1'b1;
    step();
    dact = 1'b0;
  endtask

  initial begin
    int nv;
    #12;
    check("rst_result", result, '0);
    check("rst_valid", {31'd0, rslt_valid}, '0);
    check("rst_busy", {31'd0, busy}, '0);
    check("rst_out_rd", {27'd0, out_rd}, '0);
    rst_n = 1'b1;
    step();

    dact = 1'b1;
    step();
    dact = 1'b0;
    check("idle_dact_busy", {31'd0, busy}, '0);

    do_op("divu",    3'b101, 1'b0, 32'd100, 32'd7, 5'd3, 32'd14, LAT_FULL, 0, 1'b0);
    do_op("remu",    3'b111, 1'b1, 32'd100, 32'd7, 5'd4, 32'd2,  LAT_FULL, 0, 1'b0);
    do_op("div_neg", 3'b100, 1'b0, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, LAT_FULL, 0, 1'b0);
    do_op("rem_neg", 3'b110, 1'b1, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, LAT_FULL, 0, 1'b0);
    do_op("div_z",   3'b100, 1'b0, 32'h12345678, 32'd0, 5'd7, 32'hFFFFFFFF, LAT_SPC, 0, 1'b0);
    do_op("rem_z",   3'b110, 1'b1, 32'h12345678, 32'd0, 5'd8, 32'h12345678, LAT_SPC, 0, 1'b0);
    do_op("divu_z",  3'b101, 1'b0, 32'h00000055, 32'd0, 5'd9, 32'hFFFFFFFF, LAT_SPC, 0, 1'b0);
    do_op("div_ovf", 3'b100, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, LAT_SPC, 0, 1'b0);
    do_op("rem_ovf", 3'b110, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h0, LAT_SPC, 0, 1'b0);
    do_op("divu_big",3'b101, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h0, LAT_FULL, 0, 1'b0);
    do_op("rem_mix", 3'b110, 1'b1, 32'd7, 32'hFFFFFFFE, 5'd13, 32'd1, LAT_FULL, 0, 1'b0);
    do_op("relatch", 3'b101, 1'b0, 32'd1000, 32'd10, 5'd14, 32'd100, LAT_FULL, 0, 1'b1);
    do_op("ld_calc", 3'b101, 1'b0, 32'd100, 32'd7, 5'd15, 32'd14, LAT_FULL, 5, 1'b0);

    start_op(32'd100, 32'd7, 5'd16);
    for (int i = 1; i < 10; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, '0);
    check("flush_valid", {31'd0, rslt_valid}, '0);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rslt_valid) nv++;
    end
    check("flush_no_valid", W'(nv), '0);
    do_op("after_flush", 3'b101, 1'b0, 32'd9, 32'd3, 5'd17, 32'd3, LAT_FULL, 0, 1'b0);

    start_op(32'd100, 32'd7, 5'd18);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    check("rst_mid_result", result, '0);
    check("rst_mid_valid", {31'd0, rslt_valid}, '0);
    check("rst_mid_busy", {31'd0, busy}, '0);
    check("rst_mid_out_rd", {27'd0, out_rd}, '0);
    #4;
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rslt_valid) nv++;
    end
    check("rst_no_valid", W'(nv), '0);
    do_op("after_rst", 3'b100, 1'b0, 32'd21, 32'hFFFFFFFD, 5'd19, 32'hFFFFFFF9, LAT_FULL, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter W, default 32, giving the operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port div_load  input  1  latch operands, funct3 and rd tag.
REQ-005 SHALL have port dact  input  1  start the division on the latched operands.
REQ-006 SHALL have port flush  input  1  abort any operation and return to IDLE.
REQ-007 SHALL have port funct3  input  3  M-ext code: DIV=100, DIVU=101, REM=110, REMU=111.
REQ-008 SHALL have port div_res_sel  input  1  0 selects quotient, 1 selects remainder; latched with div_load.
REQ-009 SHALL have port lhs  input  W  dividend.
REQ-010 SHALL have port rhs  input  W  divisor.
REQ-011 SHALL have port in_rd  input  5  destination tag.
REQ-012 SHALL have port result  output  W  selected quotient or remainder.
REQ-013 SHALL have port rslt_valid  output  1  one-cycle pulse: result and out_rd are valid.
REQ-014 SHALL have port out_rd  output  5  tag latched at div_load.
REQ-015 SHALL have port busy  output  1  high in states LOADED, CALC, FIX.

Function
REQ-016 SHALL implement the FSM states IDLE, LOADED, CALC, FIX and DONE.
REQ-017 SHALL, in IDLE or DONE, latch lhs, rhs, funct3, div_res_sel and in_rd when div_load=1 and go to LOADED; dact in the same cycle is ignored.
REQ-018 SHALL, in LOADED, re-latch all inputs when div_load=1 (div_load has priority); otherwise dact=1 goes to CALC, loads the iteration counter with W, and loads the working operands.
REQ-019 SHALL ignore dact in IDLE and DONE, and SHALL ignore div_load in CALC and FIX.
REQ-020 SHALL treat the operation as signed when funct3[0]=0 and use the absolute values of both operands in that case; unsigned operations use the operands as is.
REQ-021 SHALL, in CALC, perform one restoring shift-subtract step per cycle (one quotient bit each) and decrement the counter, leaving for FIX when the counter reaches 0.
REQ-022 SHALL, in FIX (one cycle), apply signs: negate the quotient when the operand signs differ and the divisor is nonzero; the remainder takes the dividend's sign.
REQ-023 SHALL produce a divide-by-zero result of quotient = all ones and remainder = dividend, for both signed and unsigned.
REQ-024 SHALL produce a signed overflow result (lhs = 2^(W-1), rhs = -1) of quotient = 2^(W-1) and remainder = 0.
REQ-025 SHALL, in DONE, assert rslt_valid for exactly one cycle, then remain in DONE with rslt_valid=0 and result held until the next div_load.
REQ-026 SHALL have a latency in which rslt_valid is high in cycle W+2 after the edge that samples dact (W CALC cycles, 1 FIX cycle, then DONE).
REQ-027 SHALL, on flush=1 in any state, go to IDLE at the next edge with rslt_valid=0; flush has priority over div_load and dact.
REQ-028 SHALL have no ready/stall back-pressure; the consumer must capture result while rslt_valid=1.

Reset
REQ-029 SHALL, while rst_n=0, immediately force: state=IDLE, result=0, rslt_valid=0, busy=0, out_rd=0, counter=0, and all latched operands=0.
REQ-030 SHALL discard an in-flight operation when reset asserts, with no rslt_valid afterwards.

Configuration
REQ-031 SHALL, with DIV_SEQ_EARLY_OUT_EN defined, detect divide-by-zero and signed overflow on entry to CALC, skip the iterations, go directly to FIX, and assert rslt_valid in cycle 2 after the dact-sampling edge.
REQ-032 SHALL, without DIV_SEQ_EARLY_OUT_EN, run every operation through the full W iterations, with the special-case values of REQ-023 and REQ-024 still produced in FIX.

Verification
REQ-033 SHALL cover: DIVU lhs=100, rhs=7, sel=0 -> result=14, rslt_valid at cycle 34 after dact; repeated with REMU -> result=2.
REQ-034 SHALL cover: DIV lhs=-7, rhs=2 -> result=0xFFFFFFFD; REM with the same operands -> result=0xFFFFFFFF.
REQ-035 SHALL cover: DIV lhs=0x12345678, rhs=0 -> result=0xFFFFFFFF; REM with the same operands -> result=0x12345678; latency 34 without the macro, 2 with it.
REQ-036 SHALL cover: DIV lhs=0x80000000, rhs=0xFFFFFFFF -> result=0x80000000; REM with the same operands -> result=0.
REQ-037 SHALL cover: flush in CALC cycle 10 -> busy=0 next cycle and no rslt_valid; a following load+dact of 9/3 -> result=3.
REQ-038 SHALL cover: rst_n low mid-CALC -> all outputs 0 immediately; div_load during CALC has no effect on the result.
